// File: rtl/soc_msp430_ram_dma_pkg.sv
// Shared types and constants for the RAM word-copy DMA engine and its port arbiter.
package soc_msp430_ram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

    localparam logic [1:0] WEN_NONE = 2'b11;
    localparam logic [1:0] WEN_WORD = 2'b00;

endpackage

// File: rtl/soc_msp430_ram_port_mux.sv
// Combinational RAM port select: the CPU always wins, and the DMA gets the port only in cycles the CPU leaves idle.
module soc_msp430_ram_port_mux
    import soc_msp430_ram_dma_pkg::*;
#(
    parameter int ADDR_MSB = 6
) (
    input  logic [ADDR_MSB:0] i_cpu_addr,
    input  logic              i_cpu_cen,
    input  logic [15:0]       i_cpu_din,
    input  logic [1:0]        i_cpu_wen,
    input  logic              i_dma_req,
    input  logic [ADDR_MSB:0] i_dma_addr,
    input  logic [15:0]       i_dma_din,
    input  logic [1:0]        i_dma_wen,
    output logic              o_dma_gnt,
    output logic [ADDR_MSB:0] o_ram_addr,
    output logic              o_ram_cen,
    output logic [15:0]       o_ram_din,
    output logic [1:0]        o_ram_wen
);

    // Grant means "CPU idle this cycle"; the FSM only acts on it in RD/WR.
    assign o_dma_gnt = i_cpu_cen;

    always_comb begin
        o_ram_addr = i_dma_addr;
        o_ram_din  = i_dma_din;
        o_ram_cen  = ~i_dma_req;
        o_ram_wen  = i_dma_req ? i_dma_wen : WEN_NONE;
        if (!i_cpu_cen) begin
            o_ram_addr = i_cpu_addr;
            o_ram_din  = i_cpu_din;
            o_ram_cen  = 1'b0;
            o_ram_wen  = i_cpu_wen;
        end
    end

endmodule

// File: rtl/soc_msp430_ram_dma.sv
// Word-copy DMA engine in front of the single-port data RAM; copies ascending, one word per RD/WR pair.
module soc_msp430_ram_dma
    import soc_msp430_ram_dma_pkg::*;
#(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [ADDR_MSB:0] cpu_addr,
    input  logic              cpu_cen,
    input  logic [15:0]       cpu_din,
    input  logic [1:0]        cpu_wen,
    output logic [15:0]       cpu_dout,
    input  logic              dma_start,
    input  logic [ADDR_MSB:0] dma_src,
    input  logic [ADDR_MSB:0] dma_dst,
    input  logic [ADDR_MSB:0] dma_len,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_err,
    output logic [1:0]        dma_state,
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [15:0]       ram_din,
    output logic [1:0]        ram_wen,
    input  logic [15:0]       ram_dout
);

    localparam logic [ADDR_MSB+1:0] WORDS = (ADDR_MSB+2)'(MEM_SIZE / 2);
    localparam logic [ADDR_MSB:0]   ONE   = (ADDR_MSB+1)'(1);

    dma_state_t        r_state;
    logic [ADDR_MSB:0] r_src;
    logic [ADDR_MSB:0] r_dst;
    logic [ADDR_MSB:0] r_cnt;
    logic [15:0]       r_data;
    logic              r_rd_pend;
    logic              r_err;

    logic                w_req;
    logic                w_gnt;
    logic [ADDR_MSB:0]   w_dma_addr;
    logic [1:0]          w_dma_wen;
    logic [15:0]         w_dma_din;
    logic [ADDR_MSB+1:0] w_src_end;
    logic [ADDR_MSB+1:0] w_dst_end;
    logic                w_range_bad;

    // Reset gates the request so an access in the reset cycle never reaches the RAM.
    assign w_req      = ~puc_rst & ((r_state == ST_RD) | (r_state == ST_WR));
    assign w_dma_addr = (r_state == ST_RD) ? r_src : r_dst;
    assign w_dma_wen  = (r_state == ST_WR) ? WEN_WORD : WEN_NONE;
    // The first WR cycle forwards the read data straight from the RAM output.
    assign w_dma_din  = r_rd_pend ? ram_dout : r_data;

    assign w_src_end   = {1'b0, dma_src} + {1'b0, dma_len};
    assign w_dst_end   = {1'b0, dma_dst} + {1'b0, dma_len};
    assign w_range_bad = (w_src_end > WORDS) | (w_dst_end > WORDS);

    soc_msp430_ram_port_mux #(
        .ADDR_MSB (ADDR_MSB)
    ) u_port_mux (
        .i_cpu_addr (cpu_addr),
        .i_cpu_cen  (cpu_cen),
        .i_cpu_din  (cpu_din),
        .i_cpu_wen  (cpu_wen),
        .i_dma_req  (w_req),
        .i_dma_addr (w_dma_addr),
        .i_dma_din  (w_dma_din),
        .i_dma_wen  (w_dma_wen),
        .o_dma_gnt  (w_gnt),
        .o_ram_addr (ram_addr),
        .o_ram_cen  (ram_cen),
        .o_ram_din  (ram_din),
        .o_ram_wen  (ram_wen)
    );

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_rd_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dma_start) begin
                        if (dma_len == '0) begin
                            r_err   <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (w_range_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_src   <= dma_src;
                            r_dst   <= dma_dst;
                            r_cnt   <= dma_len;
                            r_err   <= 1'b0;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (w_gnt) begin
                        r_rd_pend <= 1'b1;
                        r_state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    // Capture unconditionally: the RAM output is only valid this one cycle.
                    if (r_rd_pend) begin
                        r_data    <= ram_dout;
                        r_rd_pend <= 1'b0;
                    end
                    if (w_gnt) begin
                        r_src   <= r_src + ONE;
                        r_dst   <= r_dst + ONE;
                        r_cnt   <= r_cnt - ONE;
                        r_state <= (r_cnt == ONE) ? ST_DONE : ST_RD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_dout  = ram_dout;
    assign dma_busy  = (r_state != ST_IDLE);
    assign dma_done  = (r_state == ST_DONE);
    assign dma_err   = r_err;
    assign dma_state = r_state;

endmodule

// File: tb/tb_soc_msp430_ram_dma.sv
// Bench for soc_msp430_ram_dma with a behavioural RAM and a forward-copy reference model.
module tb_soc_msp430_ram_dma;
    import soc_msp430_ram_dma_pkg::*;

    localparam int WORDS = 128;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [6:0]  cpu_addr;
    logic        cpu_cen;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_wen;
    logic [15:0] cpu_dout;
    logic        dma_start;
    logic [6:0]  dma_src, dma_dst, dma_len;
    logic        dma_busy, dma_done, dma_err;
    logic [1:0]  dma_state;
    logic [6:0]  ram_addr;
    logic        ram_cen;
    logic [15:0] ram_din;
    logic [1:0]  ram_wen;
    logic [15:0] ram_dout;

    int tests = 0;
    int fails = 0;
    int busy_cnt = 0, done_cnt = 0, done_at = 0, wr_cnt = 0, acc_cnt = 0;

    logic [15:0] mem [0:WORDS-1];
    logic [15:0] mdl [0:WORDS-1];
    logic [15:0] exp_q [$];

    soc_msp430_ram_dma dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .cpu_addr(cpu_addr), .cpu_cen(cpu_cen), .cpu_din(cpu_din), .cpu_wen(cpu_wen), .cpu_dout(cpu_dout),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err), .dma_state(dma_state),
        .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_din(ram_din), .ram_wen(ram_wen), .ram_dout(ram_dout)
    );

    // clock / reset
    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // single-port RAM: registered read data, byte write enables active low
    always @(posedge mclk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= mem[ram_addr];
            if (ram_wen != 2'b11) wr_cnt++;
            if (cpu_cen) acc_cnt++;
        end
    end

    always @(negedge mclk) begin
        if (dma_busy === 1'b1) busy_cnt++;
        if (dma_done === 1'b1) begin
            done_cnt++;
            done_at = busy_cnt;
        end
    end

    // driver tasks
    task step();
        @(posedge mclk);
        #1;
    endtask

    task idle_in();
        cpu_cen   = 1'b1;
        cpu_wen   = 2'b11;
        cpu_addr  = '0;
        cpu_din   = '0;
        dma_start = 1'b0;
        dma_src   = '0;
        dma_dst   = '0;
        dma_len   = '0;
    endtask

    task start_dma(input int s, input int d, input int l);
        dma_src   = 7'(s);
        dma_dst   = 7'(d);
        dma_len   = 7'(l);
        dma_start = 1'b1;
        step();
        dma_start = 1'b0;
    endtask

    task wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (dma_busy === 1'b1 && n < 1000);
        tests++;
        if (dma_busy === 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, dma_busy, n);
        end
    endtask

    // forward copy model: word by word ascending, so overlapping dst>src smears
    task model_copy(input int s, input int d, input int l);
        for (int i = 0; i < l; i++) mdl[d+i] = mdl[s+i];
        for (int i = 0; i < l; i++) exp_q.push_back(mdl[d+i]);
    endtask

    task check_copy(input string name, input int d);
        int i;
        logic [15:0] e;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (mem[d+i] !== e) begin
                fails++;
                $display("FAIL %s_word[%0d]: got %h, required %h", name, d+i, mem[d+i], e);
            end
            i++;
        end
    endtask

    task fill_mem();
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 16'($urandom);
            mdl[i] = mem[i];
        end
    endtask

    task check_timing(input string name, input int b0, input int d0, input int exp_busy);
        tests++;
        if (busy_cnt - b0 !== exp_busy) begin
            fails++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cnt - b0, exp_busy);
        end
        tests++;
        if (done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt - d0);
        end
        tests++;
        if (done_at - b0 !== exp_busy) begin
            fails++;
            $display("FAIL %s_done_pos: got busy cycle %0d, required %0d", name, done_at - b0, exp_busy);
        end
    endtask

    // scenarios
    task test_reset();
        puc_rst = 1'b1;
        idle_in();
        step();
        step();
        @(negedge mclk);
        tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", dma_busy); end
        tests++; if (dma_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, required 0", dma_done); end
        tests++; if (dma_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b, required 0", dma_err); end
        tests++; if (ram_cen !== 1'b1) begin fails++; $display("FAIL rst_cen: got %b, required 1", ram_cen); end
        tests++; if (ram_wen !== 2'b11) begin fails++; $display("FAIL rst_wen: got %b, required 11", ram_wen); end
        tests++; if (dma_state !== 2'(ST_IDLE)) begin fails++; $display("FAIL rst_state: got %0d, required %0d", dma_state, ST_IDLE); end
        puc_rst = 1'b0;
        step();
    endtask

    task test_basic();
        int b0, d0;
        fill_mem();
        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'h1111 * 16'(i + 1);
            mdl[i] = mem[i];
        end
        model_copy(0, 'h40, 4);
        b0 = busy_cnt; d0 = done_cnt;
        start_dma(0, 'h40, 4);
        wait_idle("basic");
        check_copy("basic", 'h40);
        check_timing("basic", b0, d0, 9);
    endtask

    task test_stall();
        int b0, d0;
        fill_mem();
        model_copy(0, 'h40, 4);
        b0 = busy_cnt; d0 = done_cnt;
        start_dma(0, 'h40, 4);
        step();
        cpu_cen = 1'b0; cpu_addr = 7'h20; cpu_wen = 2'b11;
        repeat (3) step();
        cpu_cen = 1'b1;
        wait_idle("stall");
        check_copy("stall", 'h40);
        check_timing("stall", b0, d0, 12);
    endtask

    task test_cpu_prio();
        fill_mem();
        mem['h10] = 16'hBEEF; mdl['h10] = 16'hBEEF;
        mem[0]    = 16'h1234; mdl[0]    = 16'h1234;
        model_copy(0, 'h50, 1);
        start_dma(0, 'h50, 1);
        cpu_cen = 1'b0; cpu_addr = 7'h10; cpu_wen = 2'b11;
        step();
        cpu_cen = 1'b1;
        @(negedge mclk);
        tests++;
        if (cpu_dout !== 16'hBEEF) begin
            fails++;
            $display("FAIL prio_cpu_dout: got %h, required beef", cpu_dout);
        end
        wait_idle("prio");
        check_copy("prio", 'h50);
    endtask

    task test_range_err();
        int w0;
        fill_mem();
        w0 = wr_cnt;
        start_dma('h7E, 0, 3);
        step();
        @(negedge mclk);
        tests++; if (dma_err !== 1'b1) begin fails++; $display("FAIL err_src_flag: got %b, required 1", dma_err); end
        tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL err_src_busy: got %b, required 0", dma_busy); end
        start_dma(0, 'h7F, 2);
        @(negedge mclk);
        tests++; if (dma_err !== 1'b1) begin fails++; $display("FAIL err_dst_flag: got %b, required 1", dma_err); end
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL err_writes: got %0d, required 0", wr_cnt - w0); end
        // exactly reaching the top of RAM is legal and clears the sticky error
        model_copy('h7D, 'h10, 3);
        start_dma('h7D, 'h10, 3);
        @(negedge mclk);
        tests++; if (dma_err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b, required 0", dma_err); end
        tests++; if (dma_busy !== 1'b1) begin fails++; $display("FAIL err_edge_busy: got %b, required 1", dma_busy); end
        wait_idle("edge");
        check_copy("edge", 'h10);
    endtask

    task test_len0();
        int b0, d0, a0;
        b0 = busy_cnt; d0 = done_cnt; a0 = acc_cnt;
        start_dma(5, 6, 0);
        wait_idle("len0");
        check_timing("len0", b0, d0, 1);
        tests++;
        if (acc_cnt - a0 !== 0) begin fails++; $display("FAIL len0_access: got %0d, required 0", acc_cnt - a0); end
    endtask

    task test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            mem[i] = 16'hA000 + 16'(i);
            mem['h40+i] = 16'h0000;
        end
        start_dma(0, 'h40, 5);
        repeat (5) step();
        tests++;
        if (dma_state !== 2'(ST_WR)) begin fails++; $display("FAIL rmid_pre_state: got %0d, required %0d", dma_state, ST_WR); end
        puc_rst = 1'b1;
        step();
        tests++; if (dma_state !== 2'(ST_IDLE)) begin fails++; $display("FAIL rmid_state: got %0d, required 0", dma_state); end
        tests++; if ({dma_busy, dma_done, dma_err} !== 3'b000) begin fails++; $display("FAIL rmid_flags: got %b, required 000", {dma_busy, dma_done, dma_err}); end
        tests++; if (ram_cen !== 1'b1) begin fails++; $display("FAIL rmid_cen: got %b, required 1", ram_cen); end
        puc_rst = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem['h40+i] !== ((i < 2) ? 16'hA000 + 16'(i) : 16'h0000)) begin
                fails++;
                $display("FAIL rmid_word[%0d]: got %h, required %h", i, mem['h40+i], (i < 2) ? 16'hA000 + 16'(i) : 16'h0000);
            end
        end
    endtask

    task test_random();
        int l, s, d, d0, bad;
        bit stop;
        for (int it = 0; it < 12; it++) begin
            fill_mem();
            l = $urandom_range(1, 16);
            s = $urandom_range(0, WORDS - l);
            d = $urandom_range(0, WORDS - l);
            model_copy(s, d, l);
            exp_q.delete();
            d0 = done_cnt;
            stop = 1'b0;
            start_dma(s, d, l);
            fork
                begin
                    while (!stop) begin
                        cpu_cen  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                        cpu_addr = 7'($urandom);
                        step();
                    end
                    cpu_cen = 1'b1;
                end
                begin
                    wait_idle("rand");
                    stop = 1'b1;
                end
            join
            bad = 0;
            for (int i = 0; i < WORDS; i++) if (mem[i] !== mdl[i]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rand_mem it=%0d src=%0d dst=%0d len=%0d: got %0d differing words, required 0", it, s, d, l, bad);
            end
            tests++;
            if (done_cnt - d0 !== 1 || dma_err !== 1'b0) begin
                fails++;
                $display("FAIL rand_status it=%0d: got done=%0d err=%b, required done=1 err=0", it, done_cnt - d0, dma_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_cpu_prio();
        test_range_err();
        test_len0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
